serial_command_receiver: RTL and testbench

SERIAL_COMMAND_RECEIVER -- requirements
Module: serial_command_receiver

---
 rtl/ccu_pkg.sv | 36 +++
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 rtl/serial_command_receiver.sv | 141 ++++++++++++++
 tb/tb_serial_command_receiver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ccu_pkg
// Brief   : Shared constants, command codes and state encodings for the
//           serial command receiver.
// Rev     : 1.0
// ============================================================================
package ccu_pkg;

    localparam logic [7:0] HDR_BYTE       = 8'hA5;
    localparam logic [7:0] CMD_SET_WINDOW = 8'h01;
    localparam logic [7:0] CMD_RUN        = 8'h02;
    localparam logic [7:0] CMD_CLEAR      = 8'h03;
    localparam logic [7:0] DEFAULT_WINDOW = 8'd4;

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        GET_CMD  = 2'd1,
        GET_DATA = 2'd2,
        GET_CHK  = 2'd3
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Brief   : Two-flop synchronizer plus 8N1 LSB-first byte receiver.
// Rev     : 1.0
// ============================================================================
module uart_rx_byte
    import ccu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(16 * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync_1, sync_2, rx_prev;
    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    shreg, shreg_next;
    logic [3:0]    bit_idx, bit_next;
    logic          bv_next, fe_next;

    // Synchronizer and edge-history flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= rx;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            shreg      <= shreg_next;
            bit_idx    <= bit_next;
            byte_valid <= bv_next;
            frame_err  <= fe_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        bit_next   = bit_idx;
        bv_next    = 1'b0;
        fe_next    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev && !sync_2) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = sync_2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {sync_2, shreg[7:1]};
                    if (bit_idx == 4'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (sync_2) begin
                        bv_next    = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (sync_2) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_data = shreg;

endmodule
`default_nettype wire

// File: rtl/serial_command_receiver.sv
`default_nettype none
// ============================================================================
// Module  : serial_command_receiver
// Brief   : UART command-frame parser (A5 CMD DATA CHK) driving control regs.
// Rev     : 1.0
// ============================================================================
module serial_command_receiver #(
    parameter int          CLKS_PER_BIT   = 10417,
    parameter logic [7:0]  DEFAULT_WINDOW = ccu_pkg::DEFAULT_WINDOW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] window,
    output logic       run_en,
    output logic       clear_counts,
    output logic       cmd_valid,
    output logic       cmd_err
);
    import ccu_pkg::*;

    localparam int TW = $clog2(16 * CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(16 * CLKS_PER_BIT - 1);

    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          frame_err;

    parser_state_t state, state_next;
    logic [7:0]    cmd_byte, cmd_next;
    logic [7:0]    data_byte, data_next;
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    window_next;
    logic          run_next, clr_next, cv_next, ce_next;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_HDR;
            cmd_byte     <= '0;
            data_byte    <= '0;
            timer        <= '0;
            window       <= DEFAULT_WINDOW;
            run_en       <= 1'b0;
            clear_counts <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            state        <= state_next;
            cmd_byte     <= cmd_next;
            data_byte    <= data_next;
            timer        <= timer_next;
            window       <= window_next;
            run_en       <= run_next;
            clear_counts <= clr_next;
            cmd_valid    <= cv_next;
            cmd_err      <= ce_next;
        end
    end

    // Every branch raises at most one of cv_next/ce_next, so the two
    // pulses are mutually exclusive by construction.
    always_comb begin
        state_next  = state;
        cmd_next    = cmd_byte;
        data_next   = data_byte;
        timer_next  = '0;
        window_next = window;
        run_next    = run_en;
        clr_next    = 1'b0;
        cv_next     = 1'b0;
        ce_next     = 1'b0;
        if (frame_err) begin
            state_next = WAIT_HDR;
            ce_next    = 1'b1;
        end else if (byte_valid) begin
            case (state)
                WAIT_HDR: begin
                    if (rx_data == HDR_BYTE) begin
                        state_next = GET_CMD;
                    end
                end
                GET_CMD: begin
                    cmd_next   = rx_data;
                    state_next = GET_DATA;
                end
                GET_DATA: begin
                    data_next  = rx_data;
                    state_next = GET_CHK;
                end
                GET_CHK: begin
                    state_next = WAIT_HDR;
                    if (rx_data != frame_chk(cmd_byte, data_byte)) begin
                        ce_next = 1'b1;
                    end else begin
                        case (cmd_byte)
                            CMD_SET_WINDOW: begin
                                if (data_byte == 8'd0) begin
                                    ce_next = 1'b1;
                                end else begin
                                    window_next = data_byte;
                                    cv_next     = 1'b1;
                                end
                            end
                            CMD_RUN: begin
                                run_next = data_byte[0];
                                cv_next  = 1'b1;
                            end
                            CMD_CLEAR: begin
                                clr_next = 1'b1;
                                cv_next  = 1'b1;
                            end
                            default: ce_next = 1'b1;
                        endcase
                    end
                end
                default: state_next = WAIT_HDR;
            endcase
        end else if (state != WAIT_HDR) begin
            // Inter-byte silence inside a frame abandons it.
            if (timer == TIMEOUT_LAST) begin
                state_next = WAIT_HDR;
                ce_next    = 1'b1;
            end else begin
                timer_next = timer + TW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_command_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_command_receiver
// Brief   : Scoreboard bench for serial_command_receiver with directed frames.
// Rev     : 1.0
// ============================================================================
module tb_serial_command_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] window;
    logic       run_en, clear_counts, cmd_valid, cmd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_err;
        bit         clear;
        logic [7:0] win;
        bit         run;
    } exp_t;

    exp_t exp_q[$];
    bit   prev_bv = 1'b0;

    serial_command_receiver #(
        .CLKS_PER_BIT   (CPB),
        .DEFAULT_WINDOW (8'd4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .window       (window),
        .run_en       (run_en),
        .clear_counts (clear_counts),
        .cmd_valid    (cmd_valid),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic expect_evt(input bit is_err, input bit clear, input logic [7:0] win, input bit run);
        exp_t e;
        e.is_err = is_err;
        e.clear  = clear;
        e.win    = win;
        e.run    = run;
        exp_q.push_back(e);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_ok);
        bit_out(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
        send_byte(k, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_window"}, window, 8'd4);
        check({tag, "_run_en"}, run_en, 0);
        check({tag, "_clear"}, clear_counts, 0);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_err"}, cmd_err, 0);
    endtask

    // Monitor: every cmd_valid/cmd_err pulse must match the next queued event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_err) begin
                check("valid_err_exclusive", 1, 0);
            end
            if (cmd_valid || cmd_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {cmd_valid, cmd_err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("evt_is_err", cmd_err, e.is_err);
                    check("evt_window", window, e.win);
                    check("evt_run_en", run_en, e.run);
                    check("evt_clear", clear_counts, e.clear);
                    if (cmd_valid) check("valid_latency", prev_bv, 1);
                end
            end else if (clear_counts) begin
                check("stray_clear", 1, 0);
            end
        end
        prev_bv = u_dut.byte_valid;
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        expect_evt(1'b0, 1'b0, 8'h10, 1'b0);
        send_frame(8'h01, 8'h10, 8'h11);
        check("win_0x10", window, 8'h10);

        expect_evt(1'b0, 1'b0, 8'h10, 1'b1);
        send_frame(8'h02, 8'h01, 8'h03);
        expect_evt(1'b0, 1'b1, 8'h10, 1'b1);
        send_frame(8'h03, 8'h00, 8'h03);
        check("run_en_kept", run_en, 1);

        expect_evt(1'b1, 1'b0, 8'h10, 1'b1);
        send_frame(8'h01, 8'h10, 8'h12);
        check("win_after_badchk", window, 8'h10);
        expect_evt(1'b0, 1'b0, 8'h08, 1'b1);
        send_frame(8'h01, 8'h08, 8'h09);

        expect_evt(1'b0, 1'b0, 8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(8'h01, 8'h20, 8'h21);
        check("win_after_garbage", window, 8'h20);

        expect_evt(1'b1, 1'b0, 8'h20, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b0);
        check("parser_wait_hdr", int'(u_dut.state), 0);
        expect_evt(1'b1, 1'b0, 8'h20, 1'b1);
        send_frame(8'h01, 8'h00, 8'h01);
        check("win_after_zero", window, 8'h20);

        expect_evt(1'b1, 1'b0, 8'h20, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (20 * CPB) @(negedge clk);
        check("win_after_timeout", window, 8'h20);

        // Reset in the middle of the DATA byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("midreset");
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("win_after_reset", window, 8'd4);
        expect_evt(1'b0, 1'b0, 8'd4, 1'b1);
        send_frame(8'h02, 8'h01, 8'h03);

        repeat (50) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
